// File: rtl/video_timing_pattern_gen.sv
// Raster timing generator (syncs, data enable, frame pulse) with four test patterns.
// Optional macro PATTERN_SCROLL_EN scrolls the pattern one pixel to the left each frame.
module video_timing_pattern_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic        i_pixclk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic [1:0]  i_pattern_sel,
  output logic [23:0] o_rgb_data,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_de,
  output logic        o_frame_start
);
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL + 1);
  localparam int unsigned VW      = $clog2(V_TOTAL + 1);
  localparam int unsigned BAR_W   = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h_reg, h_next;
  logic [VW-1:0] v_reg, v_next;
  logic [1:0]    pattern_reg, pattern_cur;
  logic          h_wrap, v_wrap, at_origin;
  logic [15:0]   h_pix, h_bar, bar_q;
  logic [7:0]    v_pix;
  logic [2:0]    bar_idx;
  logic [23:0]   bar_rgb, pix_rgb;
  logic          de_next, hsync_next, vsync_next;

  assign h_wrap    = (h_reg == H_LAST);
  assign v_wrap    = (v_reg == V_LAST);
  assign at_origin = (h_reg == '0) && (v_reg == '0);

  always_comb begin
    h_next = h_reg;
    v_next = v_reg;
    if (!i_enable) begin
      h_next = '0;
      v_next = '0;
    end else if (h_wrap) begin
      h_next = '0;
      v_next = v_wrap ? '0 : v_reg + 1'b1;
    end else begin
      h_next = h_reg + 1'b1;
    end
  end

`ifdef PATTERN_SCROLL_EN
  logic [7:0] frame_cnt_reg;

  always_ff @(posedge i_pixclk or negedge i_reset) begin
    if (!i_reset) begin
      frame_cnt_reg <= '0;
    end else if (i_enable && h_wrap && v_wrap) begin
      frame_cnt_reg <= frame_cnt_reg + 8'd1;
    end
  end

  assign h_pix = 16'(h_reg) + 16'(frame_cnt_reg);
  assign h_bar = h_pix % 16'(H_ACTIVE);
`else
  assign h_pix = 16'(h_reg);
  assign h_bar = h_pix;
`endif

  assign v_pix   = 8'(v_reg);
  assign bar_q   = h_bar / 16'(BAR_W);
  assign bar_idx = (bar_q > 16'd7) ? 3'd7 : bar_q[2:0];

  // The bar order white..black works out to red=~idx[1], green=~idx[2], blue=~idx[0].
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_bar
      localparam int IDX_BIT = (gi + 1) % 3;
      assign bar_rgb[gi*8 +: 8] = {8{~bar_idx[IDX_BIT]}};
    end
  endgenerate

  // The selection seen at the frame origin already applies to that first pixel.
  assign pattern_cur = at_origin ? i_pattern_sel : pattern_reg;

  always_comb begin
    pix_rgb = 24'h0;
    case (pattern_cur)
      2'd0:    pix_rgb = bar_rgb;
      2'd1:    pix_rgb = (h_pix[5] ^ v_pix[5]) ? 24'h000000 : 24'hFFFFFF;
      2'd2:    pix_rgb = {h_pix[7:0] + v_pix, v_pix, h_pix[7:0]};
      default: pix_rgb = 24'hFFFFFF;
    endcase
  end

  assign de_next    = (h_reg < H_ACT) && (v_reg < V_ACT);
  assign hsync_next = ((h_reg >= HS_BEG) && (h_reg < HS_END)) ? SYNC_POL : ~SYNC_POL;
  assign vsync_next = ((v_reg >= VS_BEG) && (v_reg < VS_END)) ? SYNC_POL : ~SYNC_POL;

  always_ff @(posedge i_pixclk or negedge i_reset) begin
    if (!i_reset) begin
      h_reg         <= '0;
      v_reg         <= '0;
      pattern_reg   <= '0;
      o_rgb_data    <= 24'h0;
      o_de          <= 1'b0;
      o_frame_start <= 1'b0;
      o_hsync       <= ~SYNC_POL;
      o_vsync       <= ~SYNC_POL;
    end else begin
      h_reg <= h_next;
      v_reg <= v_next;
      if (i_enable) begin
        pattern_reg   <= pattern_cur;
        o_de          <= de_next;
        o_hsync       <= hsync_next;
        o_vsync       <= vsync_next;
        o_frame_start <= at_origin;
        o_rgb_data    <= de_next ? pix_rgb : 24'h0;
      end else begin
        o_de          <= 1'b0;
        o_hsync       <= ~SYNC_POL;
        o_vsync       <= ~SYNC_POL;
        o_frame_start <= 1'b0;
        o_rgb_data    <= 24'h0;
      end
    end
  end
endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// Bench for video_timing_pattern_gen on a 24x8 raster; pixel model works from the linear
// cycle index within a frame. Define PATTERN_SCROLL_EN to also check scrolling.
module tb_video_timing_pattern_gen;
  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 4, VF = 1, VS = 1, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b1;
  logic [1:0]  sel = 2'd0;
  logic [23:0] o_rgb_data;
  logic        o_hsync, o_vsync, o_de, o_frame_start;

  int n_checks = 0;
  int n_errors = 0;

  video_timing_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0)
  ) dut (
    .i_pixclk(clk),
    .i_reset(rst_n),
    .i_enable(en),
    .i_pattern_sel(sel),
    .o_rgb_data(o_rgb_data),
    .o_hsync(o_hsync),
    .o_vsync(o_vsync),
    .o_de(o_de),
    .o_frame_start(o_frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] bar_colour(int idx);
    case (idx)
      0: return 24'hFFFFFF;
      1: return 24'h00FFFF;
      2: return 24'hFFFF00;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'h0000FF;
      6: return 24'hFF0000;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] pixel(int h, int v, int pat, int fc);
    int hs;
    if (h >= HA || v >= VA) return 24'h0;
    hs = h + fc;
    case (pat)
      0: return bar_colour((hs % HA) / (HA / 8));
      1: return ((((hs / 32) ^ (v / 32)) % 2) == 0) ? 24'hFFFFFF : 24'h000000;
      2: return {8'((hs + v) % 256), 8'(v % 256), 8'(hs % 256)};
      default: return 24'hFFFFFF;
    endcase
  endfunction

  // Reference model: t is the position of the next pixel within the frame.
  logic [23:0] exp_rgb = 24'h0;
  logic        exp_hs = 1'b1, exp_vs = 1'b1, exp_de = 1'b0, exp_fs = 1'b0;
  int t = 0, fc = 0, pat_cur = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_rgb <= 24'h0; exp_hs <= 1'b1; exp_vs <= 1'b1; exp_de <= 1'b0; exp_fs <= 1'b0;
      t <= 0; fc <= 0; pat_cur <= 0;
    end else if (!en) begin
      exp_rgb <= 24'h0; exp_hs <= 1'b1; exp_vs <= 1'b1; exp_de <= 1'b0; exp_fs <= 1'b0;
      t <= 0;
    end else begin
      exp_rgb <= pixel(t % HT, t / HT, (t == 0) ? int'(sel) : pat_cur, fc);
      exp_de  <= ((t % HT) < HA) && ((t / HT) < VA);
      exp_hs  <= !(((t % HT) >= HA + HF) && ((t % HT) < HA + HF + HS));
      exp_vs  <= !(((t / HT) >= VA + VF) && ((t / HT) < VA + VF + VS));
      exp_fs  <= (t == 0);
      if (t == 0) pat_cur <= int'(sel);
      if (t == FRAME - 1) begin
        t <= 0;
`ifdef PATTERN_SCROLL_EN
        fc <= (fc + 1) % 256;
`endif
      end else begin
        t <= t + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      n_checks++;
      if ({o_rgb_data, o_hsync, o_vsync, o_de, o_frame_start} !==
          {exp_rgb, exp_hs, exp_vs, exp_de, exp_fs}) begin
        n_errors++;
        $display("FAIL model at %0t: got rgb=%h hs=%b vs=%b de=%b fs=%b, expected rgb=%h hs=%b vs=%b de=%b fs=%b",
                 $time, o_rgb_data, o_hsync, o_vsync, o_de, o_frame_start,
                 exp_rgb, exp_hs, exp_vs, exp_de, exp_fs);
      end
    end
  endtask

  task automatic wait_fs(input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (o_frame_start !== 1'b1 && n < limit);
    chk("frame_start_seen", 32'(o_frame_start), 32'd1);
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_de"}, 32'(o_de), 32'd0);
    chk({name, "_rgb"}, 32'(o_rgb_data), 32'd0);
    chk({name, "_hsync"}, 32'(o_hsync), 32'd1);
    chk({name, "_vsync"}, 32'(o_vsync), 32'd1);
    chk({name, "_fs"}, 32'(o_frame_start), 32'd0);
  endtask

  initial begin
    int de_cnt, hs_low, vs_low, fs_cnt, hs_first, hold;
    fork
      compare_loop();
    join_none

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");

    // First frame after release: latency, bar colours, duty and sync placement.
    @(posedge clk); #3 rst_n = 1'b1;
    @(negedge clk);
    chk("fs_before_edge", 32'(o_frame_start), 32'd0);
    de_cnt = 0; hs_low = 0; vs_low = 0; fs_cnt = 0; hs_first = -1;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      if (c == 0) chk("frame_start_latency", 32'(o_frame_start), 32'd1);
      if (c == 1) chk("bar_px1_white", 32'(o_rgb_data), 32'hFFFFFF);
      if (c == 2) chk("bar_px2_yellow", 32'(o_rgb_data), 32'h00FFFF);
      if (c == 3) chk("bar_px3_yellow", 32'(o_rgb_data), 32'h00FFFF);
      if (c == 14) chk("bar_px14_black", 32'(o_rgb_data), 32'h000000);
      de_cnt += int'(o_de);
      fs_cnt += int'(o_frame_start);
      if (!o_hsync) begin
        hs_low++;
        if (hs_first < 0) hs_first = c;
      end
      if (!o_vsync) vs_low++;
    end
    chk("de_per_frame", 32'(de_cnt), 32'd64);
    chk("hsync_low_per_frame", 32'(hs_low), 32'd24);
    chk("vsync_low_per_frame", 32'(vs_low), 32'd24);
    chk("hsync_offset", 32'(hs_first), 32'd18);
    chk("fs_per_frame", 32'(fs_cnt), 32'd1);

    // Randomized enable gaps, pattern changes and occasional reset pulses.
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #3;
      if (hold > 0) begin
        hold--;
        if (hold == 0) en = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        en = 1'b0;
        hold = $urandom_range(1, 12);
      end
      if ($urandom_range(0, 79) == 0) sel = 2'($urandom_range(0, 3));
      rst_n = ($urandom_range(0, 999) != 0);
    end

    // Pattern change mid-frame only takes effect at the next frame.
    @(posedge clk); #3 rst_n = 1'b0; en = 1'b1; sel = 2'd0;
    @(posedge clk); #3 rst_n = 1'b1;
    repeat (50) @(posedge clk);
    #3 sel = 2'd2;
    @(negedge clk);
    @(negedge clk);
    chk("bars_persist", 32'(o_rgb_data), 32'h00FFFF);
    wait_fs(400);
    repeat (5) @(negedge clk);
    chk("gradient_px5", 32'(o_rgb_data), 32'h050005);

    // Enable gap mid-line, then restart from the frame origin.
    @(posedge clk); #3 en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_idle("disabled");
    repeat (9) @(posedge clk);
    #3 en = 1'b1;
    @(negedge clk);
    chk("still_idle_de", 32'(o_de), 32'd0);
    @(negedge clk);
    chk("restart_fs", 32'(o_frame_start), 32'd1);
    chk("restart_de", 32'(o_de), 32'd1);

    // Asynchronous reset mid-frame.
    repeat (30) @(posedge clk);
    #3 rst_n = 1'b0;
    @(negedge clk);
    chk_idle("async_reset");
    @(posedge clk); #3 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_fs_wait", 32'(o_frame_start), 32'd0);
    @(negedge clk);
    chk("post_reset_fs", 32'(o_frame_start), 32'd1);
    chk("post_reset_de", 32'(o_de), 32'd1);

`ifdef PATTERN_SCROLL_EN
    @(posedge clk); #3 rst_n = 1'b0; sel = 2'd2;
    @(posedge clk); #3 rst_n = 1'b1;
    wait_fs(10);
    chk("scroll_frame0_red", 32'(o_rgb_data[7:0]), 32'h00);
    repeat (FRAME) @(negedge clk);
    chk("scroll_frame1_fs", 32'(o_frame_start), 32'd1);
    chk("scroll_frame1_red", 32'(o_rgb_data[7:0]), 32'h01);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/video_timing_pattern_gen.md
VIDEO_TIMING_PATTERN_GEN -- requirements
Module: video_timing_pattern_gen

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- SYNC_POL, 0, sync active level (0 = active-low)
REQ-002 Ports (name, direction, width, meaning), one per line:
- i_pixclk, in, 1, pixel clock (only clock)
- i_reset, in, 1, asynchronous active-low reset
- i_enable, in, 1, run timing when 1
- i_pattern_sel, in, 2, 0 colour bars, 1 checkerboard, 2 gradient, 3 solid white
- o_rgb_data, out, 24, {blue[23:16], green[15:8], red[7:0]}
- o_hsync, out, 1, horizontal sync
- o_vsync, out, 1, vertical sync
- o_de, out, 1, data enable
- o_frame_start, out, 1, one-cycle pulse with first active pixel of a frame

Function
REQ-003 The block SHALL keep counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1), where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-004 h SHALL increment every cycle while i_enable=1 and wrap to 0 after H_TOTAL-1.
REQ-005 v SHALL increment on each h wrap and wrap to 0 after V_TOTAL-1.
REQ-006 Counters SHALL be 1 cycle ahead of outputs; every output is registered, so all outputs of one pixel appear in the same cycle.
REQ-007 o_de SHALL be 1 iff h < H_ACTIVE and v < V_ACTIVE.
REQ-008 o_hsync SHALL be at SYNC_POL level iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, otherwise at ~SYNC_POL.
REQ-009 o_vsync SHALL follow the same rule as REQ-008 using v and the V_* parameters, changing only at h = 0.
REQ-010 o_frame_start SHALL pulse 1 for exactly one cycle when h = 0 and v = 0.
REQ-011 o_rgb_data SHALL be 24'h0 whenever o_de = 0.
REQ-012 Colour bars: 8 bars of width H_ACTIVE/8, left to right: white, yellow, cyan, green, magenta, red, blue, black; each component is 8'hFF or 8'h00.
REQ-013 Checkerboard: 32x32 squares; white when h[5]^v[5] = 0, black otherwise.
REQ-014 Gradient: red = h[7:0], green = v[7:0], blue = (h+v)[7:0], computed modulo 256.
REQ-015 i_pattern_sel SHALL be sampled only at h = 0, v = 0; a mid-frame change takes effect at the next frame.
REQ-016 Deasserting i_enable SHALL synchronously clear h and v to 0 and drive idle outputs (o_de = 0, syncs inactive, rgb = 0, o_frame_start = 0).
REQ-017 Reasserting i_enable SHALL restart at h = 0, v = 0 with o_frame_start on the first output cycle.

Reset
REQ-018 While i_reset = 0, asynchronously: h = 0, v = 0, latched pattern = 0, o_rgb_data = 0, o_de = 0, o_frame_start = 0, o_hsync = o_vsync = ~SYNC_POL.
REQ-019 Reset release SHALL be honoured on the next i_pixclk rising edge; a mid-frame reset restarts the frame from h = 0, v = 0.

Configuration
REQ-020 With macro PATTERN_SCROLL_EN defined, an 8-bit frame counter SHALL increment at each v wrap, and pattern generation SHALL use h + frame_cnt (modulo H_ACTIVE for bars) so the pattern scrolls 1 pixel per frame.
REQ-021 Without PATTERN_SCROLL_EN, no frame counter SHALL exist and patterns are static.
REQ-022 Reset SHALL clear the frame counter to 0.

Verification (small parameters: H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=3, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=2, unless noted)
REQ-023 Reset release, i_enable=1: o_frame_start first pulses 1 cycle after release; o_de high 16 cycles out of every 24, for 4 lines out of every 8.
REQ-024 Sync check: o_hsync low for 3 cycles starting 18 cycles after o_de rises; o_vsync low for exactly 24 cycles per 192-cycle frame.
REQ-025 i_pattern_sel=0: pixels 0-1 = 24'hFFFFFF, pixels 2-3 = 24'h00FFFF (yellow), pixels 14-15 = 24'h000000.
REQ-026 Switch i_pattern_sel from 0 to 2 mid-frame: bars persist until the next o_frame_start; then pixel (h=5, v=0) = 24'h050005.
REQ-027 Drop i_enable for 10 cycles mid-line, then drop i_reset mid-frame: outputs idle immediately; on restart the sequence begins at o_frame_start with no partial line.
REQ-028 PATTERN_SCROLL_EN defined, i_pattern_sel=2: pixel (0,0) red = 8'h00 in frame 0 and 8'h01 in frame 1.
